// File: rtl/delay_share_pkg.sv
// Shared types and helpers for the shared fixed-latency delay arbiter.
//   rr_pick_t : result of a round-robin pick (found flag, one-hot, index)
//   rr_pick() : round-robin search starting just above a pointer, wrapping
//               at nreq. Operates on MAX_NREQ-wide vectors; callers
//               zero-extend and slice back to their own NREQ.
package delay_share_pkg;

  localparam int MAX_NREQ = 16;
  localparam int MAX_IDW  = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_NREQ-1:0] onehot;
    logic [MAX_IDW-1:0]  idx;
  } rr_pick_t;

  // Search order is ptr+1, ptr+2, ... wrapping at nreq; the first eligible
  // slot wins. The loop runs to MAX_NREQ so it unrolls to a fixed size; the
  // off <= nreq guard trims it to the real requester count.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] elig,
                                       input logic [MAX_IDW-1:0]  ptr,
                                       input int unsigned         nreq);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned off = 1; off <= MAX_NREQ; off++) begin
      k = (32'(ptr) + off) % nreq;
      if (off <= nreq && !r.found && elig[k[MAX_IDW-1:0]]) begin
        r.found                    = 1'b1;
        r.onehot[k[MAX_IDW-1:0]]   = 1'b1;
        r.idx                      = k[MAX_IDW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_share_arb_rr.sv
// Combinational round-robin arbiter.
//   i_elig    : per-requester eligibility (valid & mask)
//   i_ptr     : last granted index; search starts at i_ptr+1
//   o_gnt     : one-hot grant (all zero when nothing eligible)
//   o_gnt_idx : index of the granted requester
//   o_gnt_vld : a grant was issued this cycle
// The pointer register lives in the parent.
module rr_arbiter
  import delay_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx,
  output logic            o_gnt_vld
);

  localparam int unsigned NREQ_U = NREQ;

  rr_pick_t pick;
  logic     unused_pick;

  always_comb begin
    pick = rr_pick(MAX_NREQ'(i_elig), MAX_IDW'(i_ptr), NREQ_U);
  end

  assign o_gnt     = pick.onehot[NREQ-1:0];
  assign o_gnt_idx = pick.idx[IDW-1:0];
  assign o_gnt_vld = pick.found;

  // High bits of the widened pick are always zero for NREQ < MAX_NREQ.
  assign unused_pick = ^{pick.onehot, pick.idx};

endmodule

// File: rtl/delay_share_arb.sv
// Shares one DELAY-stage register pipeline among NREQ requesters.
// A round-robin arbiter grants at most one requester per cycle; the granted
// data enters stage 0 with its requester id and emerges DELAY cycles later
// as a one-cycle response.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_req_valid     : per-requester request valid
//   i_req_data      : packed data, requester k at [k*DWIDTH +: DWIDTH]
//   i_req_mask      : 1 = requester may be granted
//   o_req_ready     : one-hot grant, transfer on valid & ready
//   o_rsp_valid/id/data : delayed item, straight from the last stage flops
//   o_inflight      : items currently in the pipeline (<= DELAY)
//   o_busy          : o_inflight != 0
module delay_share_arb
  import delay_share_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DWIDTH = 8,
  parameter  int DELAY  = 2,
  localparam int IDW    = $clog2(NREQ),
  localparam int CW     = $clog2(DELAY+1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*DWIDTH-1:0] i_req_data,
  input  logic [NREQ-1:0]        i_req_mask,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_rsp_valid,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [DWIDTH-1:0]      o_rsp_data,
  output logic [CW-1:0]          o_inflight,
  output logic                   o_busy
);

  typedef struct packed {
    logic              valid;
    logic [IDW-1:0]    id;
    logic [DWIDTH-1:0] data;
  } stage_t;

  stage_t          stg_q [DELAY];
  stage_t          stg0_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [NREQ-1:0] elig, gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_vld;
  logic            acc, rsp;

  // Eligibility excludes data, so ready can never depend on i_req_data and
  // can never be asserted for a requester whose valid is low.
  assign elig = i_req_valid & i_req_mask;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_elig    (elig),
    .i_ptr     (ptr_q),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld)
  );

  assign o_req_ready = gnt;
  assign acc         = gnt_vld;
  assign rsp         = stg_q[DELAY-1].valid;

  always_comb begin
    ptr_d  = ptr_q;
    stg0_d = stg_q[0];
    stg0_d.valid = 1'b0;
    if (acc) begin
      ptr_d  = gnt_idx;
      stg0_d = '{valid: 1'b1, id: gnt_idx,
                 data: i_req_data[gnt_idx*DWIDTH +: DWIDTH]};
    end
  end

  // Accept and retire in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (acc && !rsp)      inflight_d = inflight_q + CW'(1);
    else if (!acc && rsp) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= IDW'(NREQ-1);
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Free-running pipeline: every stage advances every cycle, no stall.
  for (genvar g = 0; g < DELAY; g++) begin : g_stg
    if (g == 0) begin : g_head
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stg_q[0] <= '0;
        else          stg_q[0] <= stg0_d;
      end
    end else begin : g_body
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stg_q[g] <= '0;
        else          stg_q[g] <= stg_q[g-1];
      end
    end
  end

  assign o_rsp_valid = stg_q[DELAY-1].valid;
  assign o_rsp_id    = stg_q[DELAY-1].id;
  assign o_rsp_data  = stg_q[DELAY-1].data;
  assign o_inflight  = inflight_q;
  assign o_busy      = |inflight_q;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(acc && !rsp && inflight_q == CW'(DELAY)))
        else $error("delay_share_arb: inflight overflow");
      assert (!(rsp && !acc && inflight_q == '0))
        else $error("delay_share_arb: inflight underflow");
      assert ((o_req_ready & ~i_req_valid) == '0)
        else $error("delay_share_arb: ready without valid");
    end
  end
`endif

endmodule
